sda_port_ctrl: RTL

- Memory-mapped tri-state pin controller for the LC3 I/O space; parametrised successor of the single-pin SDA driver.
- Registers are loaded from MDR under LD_* strobes from the control unit and drive a WIDTH-bit open bus.
- Three modes: legacy single-pin level, timed single-pin pulse, and parallel masked drive.
- Adds a synchronised bus readback register and a BUSY flag for pulse mode.

---
 rtl/sda_port_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sda_port_ctrl.sv
// sda_port_ctrl: memory-mapped tri-state pin controller for the LC3 I/O space.
//
// Registers load from MDR under the LD_* strobes and drive a WIDTH-bit open bus
// in one of three modes:
//   0 = level    : pin SDASR drives SDADR[0] while SDAER[0] is set
//   1 = pulse    : pin SDASR drives SDADR[0] for L+1 cycles after a DR load
//   2 = parallel : pin i drives SDADR[i] where SDAER[i] is set
//   3 = reserved : bus released, register writes still accepted
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   MDR               write data from the memory data register
//   LD_SDA{ER,DR,SR,MR} load strobes (priority DR > ER > SR > MR)
//   SDA_BUS           tri-state pin bus
//   SDAER/DR/SR/MR    register readback, zero-extended to 16 bits
//   SDAIN             two-flop synchronised bus readback
//   WR                write acknowledge, high the cycle after any accepted load
//   BUSY              pulse in progress
module sda_port_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned PULSE_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      MDR,
   input  logic             LD_SDAER,
   input  logic             LD_SDADR,
   input  logic             LD_SDASR,
   input  logic             LD_SDAMR,
   inout  wire  [WIDTH-1:0] SDA_BUS,
   output logic [15:0]      SDAER,
   output logic [15:0]      SDADR,
   output logic [15:0]      SDASR,
   output logic [15:0]      SDAMR,
   output logic [15:0]      SDAIN,
   output logic             WR,
   output logic             BUSY
);

   typedef enum logic {StIdle, StPulse} state_e;

   logic [WIDTH-1:0]   dr_q, er_q;
   logic [SEL_W-1:0]   sr_q;
   logic [1:0]         mode_q;
   logic [PULSE_W-1:0] plen_q;
   logic               wr_q;
   state_e             state_q, state_d;
   logic [PULSE_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   sync1_q, sync2_q;

   logic ld_dr, ld_er, ld_sr, ld_mr, any_ld;
   logic sel_ok;
   logic [WIDTH-1:0] sel_hit, bus_oe, bus_out;

   // Only the highest-priority asserted strobe is accepted.
   assign ld_dr  = LD_SDADR;
   assign ld_er  = LD_SDAER & ~LD_SDADR;
   assign ld_sr  = LD_SDASR & ~LD_SDAER & ~LD_SDADR;
   assign ld_mr  = LD_SDAMR & ~LD_SDASR & ~LD_SDAER & ~LD_SDADR;
   assign any_ld = LD_SDADR | LD_SDAER | LD_SDASR | LD_SDAMR;

   // Register file and write acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dr_q   <= '0;
         er_q   <= '0;
         sr_q   <= '0;
         mode_q <= '0;
         plen_q <= '0;
         wr_q   <= 1'b0;
      end else begin
         wr_q <= any_ld;
         if (ld_dr) dr_q <= MDR[WIDTH-1:0];
         if (ld_er) er_q <= MDR[WIDTH-1:0];
         if (ld_sr) sr_q <= MDR[SEL_W-1:0];
         if (ld_mr) begin
            mode_q <= MDR[1:0];
            plen_q <= MDR[8 +: PULSE_W];
         end
      end
   end

   // Pulse FSM state and down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter runs L..0, giving L+1 driven cycles. An abort beats a
   // restart, which beats the natural end of the pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (mode_q == 2'd1 && ld_dr && er_q[0]) begin
               state_d = StPulse;
               cnt_d   = plen_q;
            end
         end
         StPulse: begin
            if (ld_mr || (ld_er && !MDR[0])) begin
               state_d = StIdle;
            end else if (ld_dr) begin
               cnt_d = plen_q;
            end else if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Selected-pin decode; out-of-range selects match no pin.
   assign sel_ok = 32'(sr_q) < WIDTH;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign sel_hit[i] = sel_ok && (32'(sr_q) == i);
      assign SDA_BUS[i] = bus_oe[i] ? bus_out[i] : 1'bz;
   end

   always_comb begin
      bus_oe  = '0;
      bus_out = {WIDTH{dr_q[0]}};
      unique case (mode_q)
         2'd0: bus_oe = er_q[0] ? sel_hit : '0;
         2'd1: bus_oe = (state_q == StPulse) ? sel_hit : '0;
         2'd2: begin
            bus_oe  = er_q;
            bus_out = dr_q;
         end
         default: bus_oe = '0;
      endcase
   end

   // Two-flop synchroniser on the resolved bus value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= SDA_BUS;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      SDAMR              = '0;
      SDAMR[1:0]         = mode_q;
      SDAMR[8 +: PULSE_W] = plen_q;
   end

   assign SDAER = 16'(er_q);
   assign SDADR = 16'(dr_q);
   assign SDASR = 16'(sr_q);
   assign SDAIN = 16'(sync2_q);
   assign WR    = wr_q;
   assign BUSY  = (state_q == StPulse);

   // MDR bits outside the register fields are don't-care.
   logic unused_mdr;
   assign unused_mdr = ^MDR;

endmodule
